inst_fetch: RTL and testbench

- Instruction fetch unit: the producer side of the instruction word consumed by the decode stage.
- Holds the PC and issues in-order 32-bit word requests to instruction memory.
- Buffers returned words with their PCs, and hands them to decode over a valid/ready interface.
- On a redirect (branch/jump/trap) it flushes buffered words, discards in-flight stale responses, and restarts at the new PC.

---
 rtl/inst_fetch_pkg.sv | 22 ++
 rtl/inst_fetch_if.sv | 32 +++
 rtl/inst_fetch_fifo.sv | 56 +++++
 rtl/inst_fetch.sv | 99 +++++++++
 tb/tb_inst_fetch.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared constants and types for the instruction fetch slice.
//   XLEN             - architectural word width
//   INST_NOP         - canonical NOP encoding (addi x0,x0,0)
//   DEFAULT_RESET_PC - default first fetch address after reset
//   fetch_entry_t    - one buffered fetch result {pc, inst}
//   word_align()     - clears the byte-offset bits of an address
package inst_fetch_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// inst_fetch_if: redirect, instruction-memory and decode-side handshakes of
// the fetch unit.
//   master - the fetch unit (drives requests and the decode-side word)
//   slave  - its environment (core control, instruction memory, decode)
interface inst_fetch_if;
    import inst_fetch_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready,
               imem_resp_valid, imem_resp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready,
               imem_resp_valid, imem_resp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
    );

endinterface

// File: rtl/inst_fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding fetched {pc, inst} entries.
//   clk, rst - clock, synchronous active-high reset
//   push/din - write an entry (ignored while full)
//   pop      - drop the head entry (ignored while empty)
//   flush    - empty the FIFO; wins over a same-cycle push
//   full, empty, count, head - status and registered head entry
// No write-to-read bypass: a pushed entry is visible the next cycle.
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit feeding the decode stage.
//   clk, rst - clock, synchronous active-high reset
//   bus      - inst_fetch_if.master: redirect input, imem request/response,
//              decode-side valid/ready instruction word with its PC
// Issues in-order word fetches from pc, tags returning words with resp_pc
// and buffers them. A redirect flushes the buffer and marks every
// in-flight request stale so its response is dropped on arrival.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    inst_fetch_if.master bus
);
    localparam int            CW  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   CAP = FIFO_DEPTH[CW:0];

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    head;
    logic [CW:0]     reserved;
    logic            req_fire;
    logic            push;
    logic            pop;

    // Every in-flight request owns a buffer slot, so a response can
    // always be accepted without backpressure.
    assign reserved           = {1'b0, outstanding} + {1'b0, fifo_count};
    assign bus.imem_req_valid = !rst && !bus.redirect_valid && (reserved < CAP);
    assign bus.imem_req_addr  = pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

    assign push = bus.imem_resp_valid && (discard == '0) && !bus.redirect_valid;
    assign pop  = bus.inst_valid && bus.inst_ready;

    assign bus.inst_valid = !fifo_empty;
    assign bus.inst       = fifo_empty ? '0 : head.inst;
    assign bus.inst_pc    = fifo_empty ? '0 : head.pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({resp_pc, bus.imem_resp_data}),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (bus.redirect_valid) begin
            // No request fires this cycle; a response arriving now is dropped,
            // everything still in flight becomes stale.
            pc          <= word_align(bus.redirect_pc);
            resp_pc     <= word_align(bus.redirect_pc);
            outstanding <= outstanding - CW'(bus.imem_resp_valid);
            discard     <= outstanding - CW'(bus.imem_resp_valid);
        end else begin
            if (req_fire) begin
                pc <= pc + 32'd4;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_resp_valid);
            if (bus.imem_resp_valid) begin
                if (discard != '0) begin
                    discard <= discard - 1'b1;
                end else begin
                    resp_pc <= resp_pc + 32'd4;
                end
            end
        end
    end

    // The slot reservation makes a push into a full buffer impossible.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && fifo_full));
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed phases plus a randomized phase for inst_fetch.
// A variable-latency in-order memory answers requests; a reference model
// tracks in-flight requests (with stale marks) and buffered words as queues.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_fetch_if bus ();

    inst_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [31:0] pc; bit stale; }          flight_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; }  word_t;
    typedef struct { logic [31:0] addr; int due; }          memreq_t;

    flight_t     flight_q[$];
    word_t       buf_q[$];
    memreq_t     mem_q[$];
    logic [31:0] pc_m = RST_PC;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat_min = 1, lat_max = 1, p_req_rdy = 100, p_inst_rdy = 100;
    bit chk_on = 0;
    bit redir_on_resp = 0;
    logic [31:0] redir_on_resp_pc = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (flight_q[i]) if (flight_q[i].stale) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model,
    // advance the model and the memory, then move to the next negedge.
    task automatic tick(input logic r, input logic rd_in, input logic [31:0] rpc_in);
        logic        rd, rv, qrdy, irdy, ev_req;
        logic [31:0] rpc, rdata;
        flight_t     f;
        rd = rd_in; rpc = rpc_in; rv = 1'b0; rdata = '0;
        if (!r && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            rv    = 1'b1;
            rdata = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        if (redir_on_resp && rv && !r) begin
            rd = 1'b1; rpc = redir_on_resp_pc; redir_on_resp = 0;
        end
        qrdy = ($urandom_range(99) < p_req_rdy);
        irdy = ($urandom_range(99) < p_inst_rdy);
        rst                 = r;
        bus.redirect_valid  = rd;
        bus.redirect_pc     = rpc;
        bus.imem_req_ready  = qrdy;
        bus.imem_resp_valid = rv;
        bus.imem_resp_data  = rdata;
        bus.inst_ready      = irdy;
        #1;
        ev_req = !r && !rd && (flight_q.size() + buf_q.size() < DEPTH);
        if (chk_on) begin
            chk("req_valid",   bus.imem_req_valid, ev_req);
            chk("req_addr",    bus.imem_req_addr,  pc_m);
            chk("inst_valid",  bus.inst_valid,     buf_q.size() > 0);
            chk("inst",        bus.inst,           buf_q.size() > 0 ? buf_q[0].inst : 32'h0);
            chk("inst_pc",     bus.inst_pc,        buf_q.size() > 0 ? buf_q[0].pc   : 32'h0);
            chk("outstanding", dut.outstanding,    flight_q.size());
            chk("discard",     dut.discard,        stale_cnt());
        end
        if (!r && bus.imem_req_valid === 1'b1 && qrdy)
            mem_q.push_back('{bus.imem_req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
        if (r) begin
            flight_q.delete(); buf_q.delete(); mem_q.delete();
            pc_m = RST_PC;
            chk_on = 1;
        end else begin
            if (buf_q.size() > 0 && irdy) void'(buf_q.pop_front());
            if (rv && flight_q.size() > 0) begin
                f = flight_q.pop_front();
                if (!rd && !f.stale) buf_q.push_back('{f.pc, mem_word(f.pc)});
            end
            if (rd) begin
                buf_q.delete();
                foreach (flight_q[i]) flight_q[i].stale = 1;
                pc_m = {rpc[31:2], 2'b00};
            end else if (ev_req && qrdy) begin
                flight_q.push_back('{pc_m, 1'b0});
                pc_m += 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        logic [31:0] hold_pc;
        rst = 1'b1;
        bus.redirect_valid = 0; bus.redirect_pc = '0; bus.imem_req_ready = 0;
        bus.imem_resp_valid = 0; bus.imem_resp_data = '0; bus.inst_ready = 0;
        @(negedge clk);
        tick(1, 0, 0);
        tick(1, 0, 0);

        // 1: streaming, 1-cycle memory, decode always ready
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0);
            if (i >= 2) chk("p1_stream_valid", bus.inst_valid, 1'b1);
        end

        // 2: decode stalled fills the buffer, then released
        p_inst_rdy = 0;
        for (int i = 0; i < 10; i++) tick(0, 0, 0);
        chk("p2_req_blocked", bus.imem_req_valid, 1'b0);
        chk("p2_buf_valid",   bus.inst_valid,     1'b1);
        p_inst_rdy = 100;
        for (int i = 0; i < 8; i++) tick(0, 0, 0);

        // 3: memory refuses requests for 3 cycles
        p_req_rdy = 0;
        hold_pc = pc_m;
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        chk("p3_addr_hold", bus.imem_req_addr, hold_pc);
        p_req_rdy = 100;
        for (int i = 0; i < 6; i++) tick(0, 0, 0);

        // 4: redirect with requests in flight and words buffered
        lat_min = 3; lat_max = 3; p_inst_rdy = 0;
        for (int i = 0; i < 6; i++) tick(0, 0, 0);
        tick(0, 1, 32'h0000_0103);
        chk("p4_redir_addr",  bus.imem_req_addr, 32'h0000_0100);
        chk("p4_redir_flush", bus.inst_valid,    1'b0);
        p_inst_rdy = 100;
        for (int i = 0; i < 12; i++) tick(0, 0, 0);

        // 5: redirect coinciding with a response, then back-to-back redirects
        lat_min = 1; lat_max = 2;
        redir_on_resp = 1; redir_on_resp_pc = 32'h0000_0180;
        for (int i = 0; i < 20 && redir_on_resp; i++) tick(0, 0, 0);
        chk("p5_resp_redir_hit", redir_on_resp, 1'b0);
        redir_on_resp = 0;
        tick(0, 0, 0);
        tick(0, 1, 32'h0000_0200);
        tick(0, 1, 32'h0000_0300);
        chk("p5_last_redir_wins", bus.imem_req_addr, 32'h0000_0300);
        for (int i = 0; i < 12; i++) tick(0, 0, 0);

        // 6: reset while the buffer is full
        lat_min = 1; lat_max = 1; p_inst_rdy = 0;
        for (int i = 0; i < 10; i++) tick(0, 0, 0);
        chk("p6_full_before", bus.inst_valid, 1'b1);
        tick(1, 0, 0);
        chk("p6_inst_valid", bus.inst_valid,  1'b0);
        chk("p6_outstanding", dut.outstanding, 32'h0);
        chk("p6_restart_pc",  bus.imem_req_addr, RST_PC);
        p_inst_rdy = 100;
        for (int i = 0; i < 6; i++) tick(0, 0, 0);

        // 7: randomized traffic with redirects and occasional resets
        lat_min = 1; lat_max = 4; p_req_rdy = 70; p_inst_rdy = 60;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(199) == 0)
                tick(1, 0, 0);
            else if ($urandom_range(99) < 4)
                tick(0, 1, $urandom());
            else
                tick(0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
